dpram_fifo_ctrl: RTL and testbench
==================================

DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, RAM address width; depth DEPTH = 2**ADDR_W entries.
REQ-002 SHALL have parameter DATA_W, default 8, RAM/FIFO data width.
REQ-003 SHALL have parameter AF_LVL, default DEPTH-4, almost-full threshold in entries.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 push  input  1  write request; push_data  input  DATA_W  write data.
REQ-007 pop  input  1  read request.
REQ-008 pop_data  output  DATA_W  read data, valid only while pop_valid=1.
REQ-009 pop_valid  output  1  one-cycle strobe, read data present.
REQ-010 full, empty, almost_full  output  1 each  status flags.
REQ-011 count  output  ADDR_W+1  entries currently stored.
REQ-012 overflow, underflow  output  1 each  sticky error flags (see Configuration).
REQ-013 ram_we_a  output  1; ram_addr_a  output  ADDR_W; ram_data_a  output  DATA_W  -- RAM write port.
REQ-014 ram_re_b  output  1; ram_addr_b  output  ADDR_W  -- RAM read port; ram_q_b  input  DATA_W  registered RAM read data (1-cycle latency).

Function
REQ-015 Push accepted iff push=1 and full=0 in the same cycle; accepted push drives ram_we_a=1, ram_addr_a=wr_ptr, ram_data_a=push_data combinationally, wr_ptr increments at clock edge.
REQ-016 Pop accepted iff pop=1 and empty=0; accepted pop drives ram_re_b=1, ram_addr_b=rd_ptr combinationally, rd_ptr increments at clock edge.
REQ-017 ram_we_a/ram_re_b SHALL be 0 in every cycle without an accepted push/pop; refused requests cause no state change besides error flags.
REQ-018 pop_valid SHALL be registered accepted-pop, asserted exactly 1 cycle after acceptance; pop_data = ram_q_b.
REQ-019 Pointers wrap DEPTH-1 -> 0 with no gap.
REQ-020 count: +1 push only, -1 pop only, unchanged on simultaneous accepted push and pop.
REQ-021 Flags registered-consistent with count: empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_LVL).
REQ-022 Simultaneous push+pop when full: pop accepted, push refused; when empty: push accepted, pop refused (no bypass).
REQ-023 Order preserved: data popped in exact push order.

Reset
REQ-024 reset=1 at a clock edge SHALL set wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_full=0, pop_valid=0, overflow=0, underflow=0.
REQ-025 While reset=1 ram_we_a=0 and ram_re_b=0 regardless of push/pop; reset mid-operation discards contents and cancels a pending pop_valid.

Configuration
REQ-026 Macro DPRAM_FIFO_ERR_FLAGS_EN defined: overflow sets on push while full, underflow sets on pop while empty; both cleared only by reset.
REQ-027 Macro undefined: overflow and underflow SHALL be tied to 0; all other behaviour identical.

Verification
REQ-028 Reset, then push 0x11,0x22,0x33 on consecutive cycles, pop 3 -> pop_valid 3 cycles, data 0x11,0x22,0x33, ending empty=1, count=0.
REQ-029 Push 64 entries (defaults) -> full=1 at count=64, almost_full=1 from count=60; 65th push -> ram_we_a=0, overflow=1 (macro on) / 0 (off).
REQ-030 Fill to 64, then push+pop same cycle -> only pop accepted, count=63; pointers wrap, next pushed value read back after 63 older ones.
REQ-031 Empty FIFO, push 0xA5 + pop same cycle -> ram_re_b=0, no pop_valid, count=1, underflow=1 (macro on); next-cycle pop returns 0xA5.
REQ-032 Steady push+pop every cycle for 200 cycles at count=5 -> count stays 5, data in order across wrap.
REQ-033 Accepted pop, reset asserted next cycle -> pop_valid=0, empty=1, count=0, flags cleared.

Source files
------------

// File: rtl/dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dpram_fifo_ctrl
// Purpose  : Synchronous FIFO controller for an external simple dual-port RAM
//            with one write port (A) and one registered read port (B, 1-cycle
//            read latency). Keeps the read/write pointers, the occupancy count
//            and the status flags. Read data is returned as a pop_valid strobe
//            one cycle after an accepted pop.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W      RAM address width; FIFO depth is 2**ADDR_W entries
//   DATA_W      data width
//   AF_LVL      almost_full threshold in entries (default depth-4)
// Ports
//   clk         clock; all logic runs on its rising edge
//   reset       synchronous, active-high reset
//   push        write request        push_data   write data
//   pop         read request
//   pop_data    read data, valid while pop_valid=1
//   pop_valid   one-cycle strobe, one cycle after an accepted pop
//   full / empty / almost_full      registered status flags
//   count       entries currently stored (0..depth)
//   overflow / underflow            sticky error flags
//   ram_we_a, ram_addr_a, ram_data_a   RAM write port
//   ram_re_b, ram_addr_b               RAM read port
//   ram_q_b     registered RAM read data
// Configuration macro
//   DPRAM_FIFO_ERR_FLAGS_EN  defined  : overflow/underflow are sticky error
//                                       flags, cleared only by reset
//                            undefined: overflow/underflow are tied to 0
// ============================================================================
module dpram_fifo_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int AF_LVL = (2 ** ADDR_W) - 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic              ram_re_b,
    output logic [ADDR_W-1:0] ram_addr_b,
    input  logic [DATA_W-1:0] ram_q_b
);

    // Occupancy value that means "full" (one more bit than the pointers)
    localparam logic [ADDR_W:0] c_FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_AF_CNT   = (ADDR_W + 1)'(AF_LVL);
    localparam logic [ADDR_W:0] c_ZERO_CNT = '0;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_almost_full;
    logic              r_pop_valid;

    logic              w_push_acc;
    logic              w_pop_acc;
    logic [ADDR_W:0]   w_count_nxt;

    // ------------------------------------------------------------------------
    // Request acceptance. Reset blocks both RAM ports outright. Acceptance is
    // decided from the registered flags only, so a push into an empty FIFO is
    // never bypassed to a same-cycle pop, and a pop from a full FIFO frees no
    // room for a same-cycle push.
    // ------------------------------------------------------------------------
    assign w_push_acc = push & ~r_full  & ~reset;
    assign w_pop_acc  = pop  & ~r_empty & ~reset;

    // RAM port drive (combinational, qualified by acceptance)
    assign ram_we_a   = w_push_acc;
    assign ram_addr_a = r_wr_ptr;
    assign ram_data_a = push_data;
    assign ram_re_b   = w_pop_acc;
    assign ram_addr_b = r_rd_ptr;

    // ------------------------------------------------------------------------
    // Next occupancy: a simultaneous accepted push and pop leaves it unchanged.
    // ------------------------------------------------------------------------
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_acc, w_pop_acc})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // ------------------------------------------------------------------------
    // Pointers, count and flags. Flags are registered from the next count so
    // they always agree with the count register in the same cycle.
    // Pointers wrap naturally through their ADDR_W-bit width.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count       <= w_count_nxt;
            r_empty       <= (w_count_nxt == c_ZERO_CNT);
            r_full        <= (w_count_nxt == c_FULL_CNT);
            r_almost_full <= (w_count_nxt >= c_AF_CNT);
        end
    end

    // ------------------------------------------------------------------------
    // Read-data strobe: aligned with the RAM's registered output. A reset in
    // the cycle after an accepted pop cancels the pending strobe.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pop_valid <= 1'b0;
        end else begin
            r_pop_valid <= w_pop_acc;
        end
    end

    assign pop_valid   = r_pop_valid;
    assign pop_data    = ram_q_b;
    assign count       = r_count;
    assign empty       = r_empty;
    assign full        = r_full;
    assign almost_full = r_almost_full;

    // ------------------------------------------------------------------------
    // Sticky error flags: a refused push (FIFO full) sets overflow, a refused
    // pop (FIFO empty) sets underflow. Only reset clears them.
    // ------------------------------------------------------------------------
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push && r_full) begin
                r_overflow <= 1'b1;
            end
            if (pop && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule : dpram_fifo_ctrl
`default_nettype wire

// File: tb/tb_dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpram_fifo_ctrl
// Purpose  : Self-checking bench for dpram_fifo_ctrl with default parameters.
//            Models the external dual-port RAM, keeps a reference model of
//            pointers/count/flags and a scoreboard of pushed data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_fifo_ctrl;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int AF_LVL = DEPTH - 4;
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
    logic              ram_we_a;
    logic [ADDR_W-1:0] ram_addr_a;
    logic [DATA_W-1:0] ram_data_a;
    logic              ram_re_b;
    logic [ADDR_W-1:0] ram_addr_b;
    logic [DATA_W-1:0] ram_q_b;

    dpram_fifo_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .AF_LVL (AF_LVL)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .ram_we_a    (ram_we_a),
        .ram_addr_a  (ram_addr_a),
        .ram_data_a  (ram_data_a),
        .ram_re_b    (ram_re_b),
        .ram_addr_b  (ram_addr_b),
        .ram_q_b     (ram_q_b)
    );

    // Clock: 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External RAM model: synchronous write, registered read
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        if (ram_re_b) ram_q_b <= mem[ram_addr_b];
    end

    // Reference model and scoreboard
    int                n_tests = 0;
    int                n_fail  = 0;
    int                m_count = 0;
    logic [ADDR_W-1:0] m_wr    = '0;
    logic [ADDR_W-1:0] m_rd    = '0;
    bit                m_ovf   = 1'b0;
    bit                m_udf   = 1'b0;
    logic [DATA_W-1:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check the
    // combinational RAM-port drive, then check registered outputs 1 ns after
    // the rising edge against the updated model.
    task automatic step(input bit rs, input bit pu, input logic [DATA_W-1:0] d, input bit po);
        bit                ap;
        bit                aq;
        logic [DATA_W-1:0] e;
        @(negedge clk);
        reset     = rs;
        push      = pu;
        push_data = d;
        pop       = po;
        ap = !rs && pu && (m_count != DEPTH);
        aq = !rs && po && (m_count != 0);
        #1;
        check("ram_we_a", 32'(ram_we_a), 32'(ap));
        check("ram_re_b", 32'(ram_re_b), 32'(aq));
        if (ap) begin
            check("ram_addr_a", 32'(ram_addr_a), 32'(m_wr));
            check("ram_data_a", 32'(ram_data_a), 32'(d));
        end
        if (aq) begin
            check("ram_addr_b", 32'(ram_addr_b), 32'(m_rd));
        end
        @(posedge clk);
        #1;
        if (rs) begin
            m_count = 0;
            m_wr    = '0;
            m_rd    = '0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            sb.delete();
        end else begin
            if (pu && m_count == DEPTH) m_ovf = ERR_EN;
            if (po && m_count == 0)     m_udf = ERR_EN;
            if (ap) begin
                sb.push_back(d);
                m_wr = m_wr + 1'b1;
            end
            if (aq) m_rd = m_rd + 1'b1;
            m_count = m_count + int'(ap) - int'(aq);
        end
        check("count",       32'(count),       32'(m_count));
        check("empty",       32'(empty),       32'(m_count == 0));
        check("full",        32'(full),        32'(m_count == DEPTH));
        check("almost_full", 32'(almost_full), 32'(m_count >= AF_LVL));
        check("overflow",    32'(overflow),    32'(m_ovf));
        check("underflow",   32'(underflow),   32'(m_udf));
        check("pop_valid",   32'(pop_valid),   32'(aq));
        if (aq) begin
            if (sb.size() == 0) begin
                check("scoreboard_nonempty", 32'(0), 32'(1));
            end else begin
                e = sb.pop_front();
                check("pop_data", 32'(pop_data), 32'(e));
            end
        end
    endtask

    // Watchdog
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        push      = 1'b0;
        push_data = '0;
        pop       = 1'b0;

        // Reset with both requests held high: RAM ports must stay idle
        step(1, 1, 8'h5A, 1);
        step(1, 0, 8'h00, 0);

        // Basic three-entry push then pop
        step(0, 1, 8'h11, 0);
        step(0, 1, 8'h22, 0);
        step(0, 1, 8'h33, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // Fill to depth (almost_full from 60, full at 64), then one more push
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i + 8'h40), 0);
        step(0, 1, 8'hFF, 0);

        // Full: simultaneous push+pop accepts only the pop
        step(0, 1, 8'hEE, 1);
        // Next value must emerge after the 63 older entries (pointer wrap)
        step(0, 1, 8'h77, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // Empty: simultaneous push+pop accepts only the push (no bypass)
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'hA5, 1);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // Steady push+pop at occupancy 5 across many pointer wraps
        for (int i = 0; i < 5; i++) step(0, 1, 8'(i + 8'hC0), 0);
        for (int i = 0; i < 200; i++) step(0, 1, 8'($urandom_range(0, 255)), 1);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);

        // Accepted pop followed by reset: strobe cancelled, FIFO cleared
        step(0, 1, 8'h01, 0);
        step(0, 1, 8'h02, 0);
        step(0, 0, 8'h00, 1);
        step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dpram_fifo_ctrl
`default_nettype wire
